// File: rtl/hex_display_arbiter_pkg.sv
// Shared definitions for the HEX3..HEX0 display arbiter: FSM states and
// the 7-segment lookup (bit0 = segment a .. bit6 = segment g, active-high).
package hex_display_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg_lut(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_display_arbiter_encoder.sv
// Combinational nibble -> 7-segment byte. Bit 7 is always 0; polarity
// inversion applies to the seven segment bits only.
module hex7seg_encoder
  import hex_display_arbiter_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [7:0] seg_byte
);

  logic [6:0] seg;

  always_comb begin
    seg = blank ? SEG_BLANK : seg_lut(nibble);
    seg_byte = {1'b0, (ACTIVE_LOW != 0) ? ~seg : seg};
  end

endmodule

// File: rtl/hex_display_arbiter.sv
// Avalon-MM master owning the HEX3..HEX0 PIO: round-robin arbitration of
// display requesters, 7-seg encoding, duplicate suppression, post-write hold.
module hex_display_arbiter
  import hex_display_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ACTIVE_LOW  = 1,
  parameter int HOLD_CYCLES = 0,
  parameter int SKIP_DUP    = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [16*NUM_REQ-1:0]  req_value,
  input  logic [4*NUM_REQ-1:0]   req_blank,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [1:0]             avm_address,
  output logic                   avm_chipselect,
  output logic                   avm_write_n,
  output logic [31:0]            avm_writedata,
  input  logic                   avm_waitrequest,
  output logic                   busy,
  output logic [1:0]             last_grant
);

  generate
    if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
      $error("hex_display_arbiter: NUM_REQ must be in 2..4");
    end
  endgenerate

  localparam logic [15:0] HOLD_LOAD  = (HOLD_CYCLES > 0) ? 16'(HOLD_CYCLES - 1) : 16'd0;
  localparam state_e      AFTER_DONE = (HOLD_CYCLES > 0) ? ST_HOLD : ST_IDLE;

  state_e      state_q, state_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic [31:0] last_word_q, last_word_d;
  logic        last_word_valid_q, last_word_valid_d;
  logic        cs_q, cs_d;
  logic        write_n_q, write_n_d;
  logic [31:0] wdata_q, wdata_d;

  logic [3:0]  valid_ext;
  logic [63:0] value_ext;
  logic [15:0] blank_ext;
  logic [2:0]  cand_sum;
  logic        grant_found;
  logic [1:0]  grant_idx;
  logic [15:0] sel_value;
  logic [3:0]  sel_blank;
  logic [31:0] enc_word;
  logic [3:0]  ready_ext;

  // Round-robin search starting at rr_ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    valid_ext   = 4'(req_valid);
    value_ext   = 64'(req_value);
    blank_ext   = 16'(req_blank);
    cand_sum    = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + 3'(k);
      if (cand_sum >= 3'(NUM_REQ)) cand_sum = cand_sum - 3'(NUM_REQ);
      if (!grant_found && valid_ext[cand_sum[1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_sum[1:0];
      end
    end
    sel_value = value_ext[{grant_idx, 4'b0000} +: 16];
    sel_blank = blank_ext[{grant_idx, 2'b00} +: 4];
  end

  // Nibble 0 is the most-significant nibble of a slice: HEX0 shows value[15:12].
  for (genvar k = 0; k < 4; k++) begin : g_enc
    hex7seg_encoder #(.ACTIVE_LOW(ACTIVE_LOW)) u_enc (
      .nibble   (sel_value[15-4*k -: 4]),
      .blank    (sel_blank[k]),
      .seg_byte (enc_word[8*k +: 8])
    );
  end

  always_comb begin
    state_d           = state_q;
    rr_ptr_d          = rr_ptr_q;
    last_grant_d      = last_grant_q;
    hold_cnt_d        = hold_cnt_q;
    last_word_d       = last_word_q;
    last_word_valid_d = last_word_valid_q;
    cs_d              = cs_q;
    write_n_d         = write_n_q;
    wdata_d           = wdata_q;
    ready_ext         = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          ready_ext    = 4'b0001 << grant_idx;
          last_grant_d = grant_idx;
          rr_ptr_d     = (grant_idx == 2'(NUM_REQ - 1)) ? 2'd0 : grant_idx + 2'd1;
          if (SKIP_DUP != 0 && last_word_valid_q && enc_word == last_word_q) begin
            state_d    = AFTER_DONE;
            hold_cnt_d = HOLD_LOAD;
          end else begin
            state_d   = ST_WRITE;
            cs_d      = 1'b1;
            write_n_d = 1'b0;
            wdata_d   = enc_word;
          end
        end
      end
      ST_WRITE: begin
        if (!avm_waitrequest) begin
          cs_d              = 1'b0;
          write_n_d         = 1'b1;
          last_word_d       = wdata_q;
          last_word_valid_d = 1'b1;
          state_d           = AFTER_DONE;
          hold_cnt_d        = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == '0) state_d = ST_IDLE;
        else                  hold_cnt_d = hold_cnt_q - 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= ST_IDLE;
      rr_ptr_q          <= '0;
      last_grant_q      <= '0;
      hold_cnt_q        <= '0;
      last_word_q       <= '0;
      last_word_valid_q <= 1'b0;
      cs_q              <= 1'b0;
      write_n_q         <= 1'b1;
      wdata_q           <= '0;
    end else begin
      state_q           <= state_d;
      rr_ptr_q          <= rr_ptr_d;
      last_grant_q      <= last_grant_d;
      hold_cnt_q        <= hold_cnt_d;
      last_word_q       <= last_word_d;
      last_word_valid_q <= last_word_valid_d;
      cs_q              <= cs_d;
      write_n_q         <= write_n_d;
      wdata_q           <= wdata_d;
    end
  end

  assign req_ready      = ready_ext[NUM_REQ-1:0];
  assign avm_address    = '0;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = write_n_q;
  assign avm_writedata  = wdata_q;
  assign busy           = (state_q != ST_IDLE);
  assign last_grant     = last_grant_q;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Scoreboard bench: stimulus queues expected grants/words, a negedge monitor
// pops and compares on every grant pulse and every completed bus write.
module tb_hex_display_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  int          cyc = 0;

  logic [1:0]  a_valid, a_ready, a_addr, a_lg;
  logic [31:0] a_value;
  logic [7:0]  a_blank;
  logic        a_cs, a_wn, a_waitreq, a_busy;
  logic [31:0] a_wdata;

  logic [1:0]  b_valid, b_ready, b_addr, b_lg;
  logic [31:0] b_value;
  logic [7:0]  b_blank;
  logic        b_cs, b_wn, b_busy;
  logic        b_waitreq = 1'b0;
  logic [31:0] b_wdata;

  int          exp_grant_q[$];
  logic [31:0] exp_word_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hex_display_arbiter #(.NUM_REQ(2), .ACTIVE_LOW(1), .HOLD_CYCLES(0), .SKIP_DUP(1)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(a_valid), .req_value(a_value),
    .req_blank(a_blank), .req_ready(a_ready), .avm_address(a_addr),
    .avm_chipselect(a_cs), .avm_write_n(a_wn), .avm_writedata(a_wdata),
    .avm_waitrequest(a_waitreq), .busy(a_busy), .last_grant(a_lg)
  );

  hex_display_arbiter #(.NUM_REQ(2), .ACTIVE_LOW(0), .HOLD_CYCLES(3), .SKIP_DUP(0)) dut_hold (
    .clk(clk), .reset_n(reset_n), .req_valid(b_valid), .req_value(b_value),
    .req_blank(b_blank), .req_ready(b_ready), .avm_address(b_addr),
    .avm_chipselect(b_cs), .avm_write_n(b_wn), .avm_writedata(b_wdata),
    .avm_waitrequest(b_waitreq), .busy(b_busy), .last_grant(b_lg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the main instance.
  int          mon_g;
  logic [31:0] mon_w;
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (a_ready != 2'b00) begin
        if (exp_grant_q.size() == 0) chk("grant_unexpected", 32'(a_ready), 32'd0);
        else begin
          mon_g = exp_grant_q.pop_front();
          chk("grant_onehot", 32'(a_ready), 32'(1 << mon_g));
        end
      end
      if (a_cs && !a_wn && !a_waitreq) begin
        if (exp_word_q.size() == 0) chk("write_unexpected", a_wdata, 32'hDEAD_BEEF);
        else begin
          mon_w = exp_word_q.pop_front();
          chk("write_word", a_wdata, mon_w);
        end
      end
    end
  end

  task automatic req_a(input int idx, input logic [15:0] val, input logic [3:0] blk,
                       input logic [31:0] word, input bit expect_write);
    bit got = 0;
    exp_grant_q.push_back(idx);
    if (expect_write) exp_word_q.push_back(word);
    @(posedge clk); #1;
    a_value[idx*16 +: 16] = val;
    a_blank[idx*4 +: 4]   = blk;
    a_valid[idx]          = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (a_ready[idx]) begin got = 1; break; end
    end
    if (!got) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    a_valid[idx] = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int grants, first_c, last_c, stable, stray, done_c, idle;
    bit got;
    reset_n = 1'b0;
    a_valid = '0; a_value = '0; a_blank = '0; a_waitreq = 1'b0;
    b_valid = '0; b_value = '0; b_blank = '0;
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(a_cs), 32'd0);
    chk("rst_write_n", 32'(a_wn), 32'd1);
    chk("rst_wdata", a_wdata, 32'd0);
    chk("rst_addr", 32'(a_addr), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_last_grant", 32'(a_lg), 32'd0);
    chk("rst_ready", 32'(a_ready), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    // First write: "1234" on an active-low display.
    req_a(0, 16'h1234, 4'h0, 32'h1930_2479, 1);
    @(negedge clk);
    chk("t1_cs_next_cycle", 32'(a_cs), 32'd1);
    chk("t1_write_n", 32'(a_wn), 32'd0);
    chk("t1_wdata", a_wdata, 32'h1930_2479);
    chk("t1_last_grant", 32'(a_lg), 32'd0);
    chk("t1_busy", 32'(a_busy), 32'd1);
    @(negedge clk);
    chk("t1_single_write", 32'(a_cs), 32'd0);

    // Both requesters continuously valid: round-robin alternation.
    exp_grant_q.push_back(1); exp_word_q.push_back(32'h2146_0308);
    exp_grant_q.push_back(0); exp_word_q.push_back(32'h4040_4040);
    exp_grant_q.push_back(1); exp_word_q.push_back(32'h2146_0308);
    exp_grant_q.push_back(0); exp_word_q.push_back(32'h4040_4040);
    @(posedge clk); #1;
    a_value = {16'hABCD, 16'h0000}; a_blank = '0; a_valid = 2'b11;
    grants = 0; first_c = 0; last_c = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (a_ready != 2'b00) begin
        if (grants == 0) first_c = cyc;
        grants++;
        if (grants == 4) begin last_c = cyc; break; end
      end
    end
    @(posedge clk); #1 a_valid = 2'b00;
    chk("rr_grant_count", 32'(grants), 32'd4);
    chk("rr_grant_spacing", 32'(last_c - first_c), 32'd6);
    @(negedge clk);

    // Stalled write: strobes and data held, no grants until completion.
    exp_grant_q.push_back(1); exp_word_q.push_back(32'h0078_0212);
    exp_grant_q.push_back(0); exp_word_q.push_back(32'h0E0E_0E0E);
    @(posedge clk); #1;
    a_waitreq = 1'b1; a_value = {16'h5678, 16'hFFFF}; a_valid = 2'b10;
    @(negedge clk);
    chk("wait_grant", 32'(a_ready), 32'h2);
    @(posedge clk); #1 a_valid = 2'b01;
    stable = 0; stray = 0;
    repeat (5) begin
      @(negedge clk);
      if (a_cs && !a_wn && a_wdata == 32'h0078_0212) stable++;
      if (a_ready != 2'b00) stray++;
    end
    @(posedge clk); #1 a_waitreq = 1'b0;
    @(negedge clk);
    if (a_cs && !a_wn && a_wdata == 32'h0078_0212) stable++;
    if (a_ready != 2'b00) stray++;
    chk("wait_stable_cycles", 32'(stable), 32'd6);
    chk("wait_no_grant", 32'(stray), 32'd0);
    got = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (a_ready[0]) begin got = 1; break; end
    end
    chk("wait_then_grant", 32'(got), 32'd1);
    @(posedge clk); #1 a_valid = 2'b00;
    @(negedge clk);

    // Duplicate word skipped, then a blanked HEX3 is written.
    req_a(1, 16'hFFFF, 4'h0, 32'd0, 0);
    @(negedge clk);
    chk("skip_no_cs", 32'(a_cs), 32'd0);
    chk("skip_idle", 32'(a_busy), 32'd0);
    req_a(0, 16'hFFFF, 4'b1000, 32'h7F0E_0E0E, 1);
    @(negedge clk);

    // Reset during a stalled write, then the same word again must be written.
    @(posedge clk); #1 a_waitreq = 1'b1;
    req_a(1, 16'h0000, 4'h0, 32'd0, 0);
    @(negedge clk);
    chk("midwrite_cs", 32'(a_cs), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_drop_cs", 32'(a_cs), 32'd0);
    chk("rst_drop_write_n", 32'(a_wn), 32'd1);
    chk("rst_drop_busy", 32'(a_busy), 32'd0);
    a_waitreq = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    req_a(0, 16'hFFFF, 4'b1000, 32'h7F0E_0E0E, 1);
    @(negedge clk);
    chk("post_rst_cs", 32'(a_cs), 32'd1);
    chk("post_rst_last_grant", 32'(a_lg), 32'd0);
    @(negedge clk);

    // Hold instance: active-high, 3 idle cycles after each write.
    @(posedge clk); #1;
    b_value = {16'h0000, 16'h1234}; b_valid = 2'b01;
    grants = 0; done_c = -1; idle = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (b_ready[0]) begin
        if (done_c >= 0) begin
          chk("hold_gap_cycles", 32'(cyc - done_c), 32'd4);
          chk("hold_busy_cycles", 32'(idle), 32'd3);
        end
        grants++;
        if (grants == 3) break;
      end else if (b_cs && !b_wn) begin
        chk("hold_word", b_wdata, 32'h664F_5B06);
        done_c = cyc; idle = 0;
      end else if (b_busy) idle++;
    end
    @(posedge clk); #1 b_valid = 2'b00;
    chk("hold_grant_count", 32'(grants), 32'd3);
    repeat (6) @(negedge clk);

    chk("grant_queue_drained", 32'(exp_grant_q.size()), 32'd0);
    chk("word_queue_drained", 32'(exp_word_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
